// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle MIPS-subset processor.
// Holds the opcode/funct encodings, the ALU operation codes, the control
// state enumeration and two decode helpers used by the control FSM.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
          default:                               ok = 1'b0;
        endcase
      end
      OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

  // beq compares by subtraction; addi/lw/sw compute with add.
  function automatic alu_op_t alu_op_of(input logic [5:0] op, input logic [5:0] funct);
    alu_op_t sel;
    sel = ALU_ADD;
    if (op == OP_BEQ) begin
      sel = ALU_SUB;
    end else if (op == OP_RTYPE) begin
      case (funct)
        FN_SUB:  sel = ALU_SUB;
        FN_AND:  sel = ALU_AND;
        FN_OR:   sel = ALU_OR;
        FN_SLT:  sel = ALU_SLT;
        default: sel = ALU_ADD;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/mc_control.sv
// Control FSM of the multicycle processor.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   op, funct         opcode/funct fields of the latched instruction
//   a_eq_b, mem_ack   branch compare and memory handshake inputs
//   mem_req, mem_we   memory request/direction
//   mem_data_sel      1 = data address on the memory port, 0 = PC
//   ir_we..retire_set datapath register enables
//   alu_op, alu_src_imm  ALU operation and B-operand select
//   trap              halted on an illegal instruction
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_FETCH  | read instruction at PC; on ack latch IR and advance PC
// S_DECODE | read rs/rt into A/B; illegal encodings go to S_TRAP
// S_EXEC   | ALU result latched; beq/j resolve PC and return to S_FETCH
// S_MEM    | data access for lw/sw, held until ack
// S_WB     | register file write, retire
// S_TRAP   | halted, no memory traffic, until reset
module mc_control
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic    a_eq_b,
  input  logic    mem_ack,
  output logic    mem_req,
  output logic    mem_we,
  output logic    mem_data_sel,
  output logic    ir_we,
  output logic    pc_inc,
  output logic    pc_branch,
  output logic    pc_jump,
  output logic    ab_we,
  output logic    alu_we,
  output logic    mdr_we,
  output logic    reg_we,
  output logic    store_we,
  output logic    retire_set,
  output alu_op_t alu_op,
  output logic    alu_src_imm,
  output logic    trap
);

  state_t state, state_next;
  // Cleared by reset and set at the first edge afterwards; keeps mem_req low
  // (asynchronously) during reset and holds off the first fetch one edge.
  logic   run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
      run   <= 1'b0;
    end else begin
      state <= state_next;
      run   <= 1'b1;
    end
  end

  always_comb begin
    state_next   = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_data_sel = 1'b0;
    ir_we        = 1'b0;
    pc_inc       = 1'b0;
    pc_branch    = 1'b0;
    pc_jump      = 1'b0;
    ab_we        = 1'b0;
    alu_we       = 1'b0;
    mdr_we       = 1'b0;
    reg_we       = 1'b0;
    store_we     = 1'b0;
    retire_set   = 1'b0;
    trap         = 1'b0;
    alu_op       = alu_op_of(op, funct);
    alu_src_imm  = (op != OP_RTYPE) && (op != OP_BEQ);

    case (state)
      S_FETCH: begin
        if (run) begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_we      = 1'b1;
            pc_inc     = 1'b1;
            state_next = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        ab_we      = 1'b1;
        state_next = is_legal(op, funct) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        alu_we = 1'b1;
        case (op)
          OP_BEQ: begin
            pc_branch  = a_eq_b;
            state_next = S_FETCH;
          end
          OP_J: begin
            pc_jump    = 1'b1;
            state_next = S_FETCH;
          end
          OP_LW, OP_SW: state_next = S_MEM;
          default:      state_next = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_we       = (op == OP_SW);
        mem_data_sel = 1'b1;
        if (mem_ack) begin
          if (op == OP_SW) begin
            store_we   = 1'b1;
            retire_set = 1'b1;
            state_next = S_FETCH;
          end else begin
            mdr_we     = 1'b1;
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        retire_set = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_processor.sv
// Multicycle MIPS-I subset processor (add, sub, and, or, slt, addi, lw, sw,
// beq, j) with a single unified memory port for fetch and data.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   mem_req/mem_we      memory request and direction (held until mem_ack)
//   mem_addr/mem_wdata  byte address and store data (0 when idle)
//   mem_rdata/mem_ack   read data and access-complete handshake
//   result              last value written to the register file
//   writeData           store data of the last sw
//   retire              one-cycle pulse per completed instruction
//   trap                high while halted on an illegal instruction
module multicycle_processor
  import cpu_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                NREGS    = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] writeData,
  output logic              retire,
  output logic              trap
);

  localparam int RI = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [DATA_W-1:0] pc, ir, a, b, alu_out, mdr;
  logic [DATA_W-1:0] regs [NREGS];

  logic              mem_data_sel, ir_we, pc_inc, pc_branch, pc_jump;
  logic              ab_we, alu_we, mdr_we, reg_we, store_we, retire_set;
  logic              alu_src_imm;
  alu_op_t           alu_op;

  logic [5:0]        op, funct;
  logic [RI-1:0]     rs_idx, rt_idx, rd_idx, wr_idx;
  logic [DATA_W-1:0] sext_imm, alu_b, alu_y, data_addr, wb_val;

  assign op       = ir[31:26];
  assign funct    = ir[5:0];
  assign rs_idx   = ir[21 +: RI];
  assign rt_idx   = ir[16 +: RI];
  assign rd_idx   = ir[11 +: RI];
  assign wr_idx   = (op == OP_RTYPE) ? rd_idx : rt_idx;
  assign sext_imm = {{(DATA_W-16){ir[15]}}, ir[15:0]};
  assign alu_b    = alu_src_imm ? sext_imm : b;
  assign data_addr = a + sext_imm;
  assign wb_val   = (op == OP_LW) ? mdr : alu_out;

  mc_control u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .op           (op),
    .funct        (funct),
    .a_eq_b       (a == b),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_data_sel (mem_data_sel),
    .ir_we        (ir_we),
    .pc_inc       (pc_inc),
    .pc_branch    (pc_branch),
    .pc_jump      (pc_jump),
    .ab_we        (ab_we),
    .alu_we       (alu_we),
    .mdr_we       (mdr_we),
    .reg_we       (reg_we),
    .store_we     (store_we),
    .retire_set   (retire_set),
    .alu_op       (alu_op),
    .alu_src_imm  (alu_src_imm),
    .trap         (trap)
  );

  // Memory outputs are forced to zero whenever no request is active, so they
  // read 0 throughout reset and stay stable across wait states.
  assign mem_addr  = !mem_req ? '0 : (mem_data_sel ? data_addr : pc);
  assign mem_wdata = (mem_req && mem_we) ? b : '0;

  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD: alu_y = a + alu_b;
      ALU_SUB: alu_y = a - alu_b;
      ALU_AND: alu_y = a & alu_b;
      ALU_OR:  alu_y = a | alu_b;
      ALU_SLT: alu_y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(alu_b))};
      default: alu_y = '0;
    endcase
  end

  // PC is already PC+4 when beq/j resolve in EXEC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (pc_inc) begin
      pc <= pc + DATA_W'(4);
    end else if (pc_branch) begin
      pc <= pc + (sext_imm << 2);
    end else if (pc_jump) begin
      pc <= {pc[DATA_W-1:28], ir[25:0], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      result    <= '0;
      writeData <= '0;
      retire    <= 1'b0;
    end else begin
      retire <= retire_set;
      if (ir_we)    ir        <= mem_rdata;
      if (ab_we)    a         <= regs[rs_idx];
      if (ab_we)    b         <= regs[rt_idx];
      if (alu_we)   alu_out   <= alu_y;
      if (mdr_we)   mdr       <= mem_rdata;
      if (reg_we)   result    <= wb_val;
      if (store_we) writeData <= b;
    end
  end

  // Register 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (reg_we && (wr_idx != '0)) begin
      regs[wr_idx] <= wb_val;
    end
  end

endmodule

// File: tb/tb_multicycle_processor.sv
module tb_multicycle_processor;

  localparam logic [5:0] OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25, FN_SLT = 6'h2A;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_we, mem_ack, retire, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, result, writeData;

  always #5 clk = ~clk;

  multicycle_processor #(.DATA_W(32), .NREGS(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .result(result), .writeData(writeData),
    .retire(retire), .trap(trap)
  );

  // memory model: ack after wait_n wait cycles
  logic [31:0] mem [0:63];
  int          wait_n = 0;
  int          wcnt;
  bit          ack_force = 1'b0;

  assign mem_ack   = ack_force | (mem_req && (wcnt == wait_n));
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk or negedge rst) begin
    if (!rst) wcnt <= 0;
    else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge clk) begin
    if (rst && mem_req && mem_ack && mem_we) mem[mem_addr[7:2]] = mem_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] res; logic [31:0] wd; int cyc; } obs_t;
  typedef struct { bit is_store; bit chk; logic [31:0] val; int dly; } exp_t;

  obs_t        obs_q[$];
  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  obs_t        mon_o;

  always @(negedge clk) begin
    if (rst) begin
      if (retire) begin
        mon_o.res = result; mon_o.wd = writeData; mon_o.cyc = cyc;
        obs_q.push_back(mon_o);
      end
      if (mem_req && mem_ack && !mem_we) rd_q.push_back(mem_addr);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {OP_J, t};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;  // word 0 decodes as illegal
    exp_q.delete();
  endtask

  task automatic push_exp(input bit st, input bit chk, input logic [31:0] v, input int dly);
    exp_t e;
    e.is_store = st; e.chk = chk; e.val = v; e.dly = dly;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    obs_q.delete();
    rd_q.delete();
    rst = 1'b1;
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin @(negedge clk); k++; end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_mem();
    mem[0] = enc_i(OP_ADDI, 5'd1, 5'd0, 16'd5);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mem_req, mem_we, retire, trap} !== 4'b0) begin
      n_bad++; $display("FAIL reset_ctl: got %b want 0000", {mem_req, mem_we, retire, trap});
    end
    n_cmp++;
    if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    n_cmp++;
    if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
    n_cmp++;
    if (result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result); end
    n_cmp++;
    if (writeData !== 32'h0) begin n_bad++; $display("FAIL reset_wd: got %h want 0", writeData); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0) begin n_bad++; $display("FAIL release_no_req: got %b want 0", mem_req); end
    @(posedge clk); #1;
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL first_fetch: got req %b addr %h want req 1 addr 0", mem_req, mem_addr);
    end
  endtask

  task automatic test_addi();
    bit ok;
    int c0 = -1;
    obs_t o;
    clear_mem();
    wait_n = 0;
    mem[0] = enc_i(OP_ADDI, 5'd1, 5'd0, 16'd5);
    do_reset();
    for (int k = 0; k < 20 && c0 < 0; k++) begin
      @(negedge clk);
      if (mem_req) c0 = cyc;
    end
    wait_obs(1, 50, ok);
    n_cmp++;
    if (!ok || c0 < 0) begin n_bad++; $display("FAIL addi_timeout: got %0d retires want 1", obs_q.size()); end
    else begin
      repeat (10) @(negedge clk);
      n_cmp++;
      if (obs_q.size() !== 1) begin n_bad++; $display("FAIL addi_pulse: got %0d retires want 1", obs_q.size()); end
      o = obs_q.pop_front();
      n_cmp++;
      if (o.res !== 32'd5) begin n_bad++; $display("FAIL addi_result: got %h want 5", o.res); end
      n_cmp++;
      if (o.cyc - c0 !== 4) begin n_bad++; $display("FAIL addi_cycles: got %0d want 4", o.cyc - c0); end
      n_cmp++;
      if (rd_q.size() < 2 || rd_q[1] !== 32'h4) begin
        n_bad++; $display("FAIL addi_next_fetch: got %0d reads want second at 4", rd_q.size());
      end
    end
  endtask

  task automatic test_alu();
    bit ok;
    int prev = 0;
    int n;
    exp_t e;
    obs_t o;
    logic [31:0] got;
    clear_mem();
    wait_n = 0;
    mem[0]  = enc_i(OP_ADDI, 5'd1, 5'd0, 16'd7);        push_exp(0, 1, 32'd7, 0);
    mem[1]  = enc_i(OP_ADDI, 5'd2, 5'd0, 16'hFFFD);     push_exp(0, 1, 32'hFFFFFFFD, 4);
    mem[2]  = enc_r(5'd3, 5'd2, 5'd1, FN_SLT);          push_exp(0, 1, 32'd1, 4);
    mem[3]  = enc_r(5'd4, 5'd2, 5'd1, FN_SUB);          push_exp(0, 1, 32'hFFFFFFF6, 4);
    mem[4]  = enc_r(5'd6, 5'd1, 5'd2, FN_AND);          push_exp(0, 1, 32'd5, 4);
    mem[5]  = enc_r(5'd7, 5'd1, 5'd2, FN_OR);           push_exp(0, 1, 32'hFFFFFFFF, 4);
    mem[6]  = enc_r(5'd8, 5'd1, 5'd2, FN_ADD);          push_exp(0, 1, 32'd4, 4);
    mem[7]  = enc_r(5'd9, 5'd1, 5'd2, FN_SLT);          push_exp(0, 1, 32'd0, 4);
    mem[8]  = enc_r(5'd10, 5'd4, 5'd4, FN_ADD);         push_exp(0, 1, 32'hFFFFFFEC, 4);
    mem[9]  = enc_i(OP_ADDI, 5'd11, 5'd7, 16'd1);       push_exp(0, 1, 32'd0, 4);
    mem[10] = enc_i(OP_SW, 5'd1, 5'd0, 16'h0080);       push_exp(1, 1, 32'd7, 4);
    mem[11] = enc_i(OP_LW, 5'd12, 5'd0, 16'h0080);      push_exp(0, 1, 32'd7, 5);
    mem[12] = enc_i(OP_BEQ, 5'd0, 5'd0, 16'd1);
    mem[13] = enc_i(OP_ADDI, 5'd13, 5'd0, 16'd99);
    mem[14] = enc_i(OP_ADDI, 5'd13, 5'd12, 16'd1);      push_exp(0, 1, 32'd8, 7);
    mem[15] = enc_j(26'd16);
    mem[16] = enc_i(OP_ADDI, 5'd14, 5'd0, 16'hFFFF);    push_exp(0, 1, 32'hFFFFFFFF, 7);
    n = exp_q.size();
    do_reset();
    wait_obs(n, 400, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL alu_timeout: got %0d retires want %0d", obs_q.size(), n); end
    else begin
      for (int i = 0; i < n; i++) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        got = e.is_store ? o.wd : o.res;
        if (e.chk) begin
          n_cmp++;
          if (got !== e.val) begin n_bad++; $display("FAIL alu_value[%0d]: got %h want %h", i, got, e.val); end
        end
        if (e.dly != 0) begin
          n_cmp++;
          if (o.cyc - prev !== e.dly) begin
            n_bad++; $display("FAIL alu_cycles[%0d]: got %0d want %0d", i, o.cyc - prev, e.dly);
          end
        end
        prev = o.cyc;
      end
    end
  endtask

  task automatic test_mem_wait();
    bit ok, stable;
    int held = 0;
    int k = 0;
    exp_t e;
    obs_t o;
    logic [31:0] got;
    clear_mem();
    wait_n = 3;
    mem[0]  = enc_j(26'd16);
    mem[2]  = 32'hDEADBEEF;
    mem[16] = enc_i(OP_ADDI, 5'd1, 5'd0, 16'd7);   push_exp(0, 1, 32'd7, 0);
    mem[17] = enc_i(OP_SW, 5'd1, 5'd0, 16'd8);     push_exp(1, 1, 32'd7, 0);
    mem[18] = enc_i(OP_LW, 5'd5, 5'd0, 16'd8);     push_exp(0, 1, 32'd7, 0);
    mem[19] = enc_r(5'd6, 5'd5, 5'd1, FN_ADD);     push_exp(0, 1, 32'd14, 0);
    do_reset();
    while (!(mem_req && mem_we) && k < 300) begin @(negedge clk); k++; end
    stable = 1'b1;
    while (mem_req && mem_we && held < 10) begin
      if (mem_addr !== 32'd8 || mem_wdata !== 32'd7) stable = 1'b0;
      held++;
      @(negedge clk);
    end
    n_cmp++;
    if (held !== 4) begin n_bad++; $display("FAIL sw_hold: got %0d cycles want 4", held); end
    n_cmp++;
    if (!stable) begin n_bad++; $display("FAIL sw_stable: got unstable addr/wdata want 8/7"); end
    wait_obs(4, 400, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL mem_timeout: got %0d retires want 4", obs_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        got = e.is_store ? o.wd : o.res;
        n_cmp++;
        if (got !== e.val) begin n_bad++; $display("FAIL mem_value[%0d]: got %h want %h", i, got, e.val); end
      end
      n_cmp++;
      if (rd_q[1] !== 32'h40) begin n_bad++; $display("FAIL jump_target: got %h want 40", rd_q[1]); end
    end
    wait_n = 0;
  endtask

  task automatic test_branch();
    bit ok;
    exp_t e;
    obs_t o;
    logic [31:0] want_next;
    for (int p = 0; p < 2; p++) begin
      clear_mem();
      wait_n = 0;
      mem[0] = enc_i(OP_ADDI, 5'd1, 5'd0, 16'd3);   push_exp(0, 1, 32'd3, 0);
      mem[1] = enc_i(OP_ADDI, 5'd0, 5'd0, 16'd9);   push_exp(0, 0, 32'd0, 0);
      mem[2] = enc_r(5'd3, 5'd0, 5'd1, FN_ADD);     push_exp(0, 1, 32'd3, 0);
      mem[3] = enc_i(OP_ADDI, 5'd2, 5'd0, 16'd4);   push_exp(0, 1, 32'd4, 0);
      mem[4] = (p == 0) ? enc_i(OP_BEQ, 5'd2, 5'd1, 16'hFFFF)
                        : enc_i(OP_BEQ, 5'd1, 5'd1, 16'hFFFF);
      mem[5] = enc_i(OP_ADDI, 5'd4, 5'd1, 16'd1);
      if (p == 0) push_exp(0, 1, 32'd4, 0);
      want_next = (p == 0) ? 32'h14 : 32'h10;
      do_reset();
      wait_obs(exp_q.size(), 200, ok);
      repeat (20) @(negedge clk);
      n_cmp++;
      if (!ok || rd_q.size() < 7) begin
        n_bad++; $display("FAIL br%0d_timeout: got %0d retires %0d reads want 7 reads", p, obs_q.size(), rd_q.size());
      end else begin
        for (int i = 0; i < 4 + (p == 0 ? 1 : 0); i++) begin
          e = exp_q.pop_front();
          o = obs_q.pop_front();
          if (e.chk) begin
            n_cmp++;
            if (o.res !== e.val) begin n_bad++; $display("FAIL br%0d_value[%0d]: got %h want %h", p, i, o.res, e.val); end
          end
        end
        n_cmp++;
        if (rd_q[4] !== 32'h10) begin n_bad++; $display("FAIL br%0d_at: got %h want 10", p, rd_q[4]); end
        n_cmp++;
        if (rd_q[5] !== want_next) begin n_bad++; $display("FAIL br%0d_next: got %h want %h", p, rd_q[5], want_next); end
        if (p == 1) begin
          n_cmp++;
          if (rd_q[6] !== 32'h10 || obs_q.size() !== 0) begin
            n_bad++; $display("FAIL br1_loop: got %h, %0d extra retires want 10, 0", rd_q[6], obs_q.size());
          end
        end
      end
    end
  endtask

  task automatic test_trap();
    for (int p = 0; p < 2; p++) begin
      clear_mem();
      wait_n = 0;
      if (p == 0) mem[0] = 32'hFC000000;
      else begin
        mem[0] = enc_i(OP_ADDI, 5'd1, 5'd0, 16'd1);
        mem[1] = enc_r(5'd2, 5'd1, 5'd1, 6'h3F);
      end
      do_reset();
      repeat (20) @(negedge clk);
      n_cmp++;
      if ({trap, mem_req} !== 2'b10) begin n_bad++; $display("FAIL trap%0d: got trap %b req %b want 1 0", p, trap, mem_req); end
      repeat (30) @(negedge clk);
      n_cmp++;
      if ({trap, mem_req} !== 2'b10 || obs_q.size() !== p || result !== 32'(p)) begin
        n_bad++; $display("FAIL trap%0d_hold: got trap %b req %b retires %0d result %h want 1 0 %0d %0d",
                          p, trap, mem_req, obs_q.size(), result, p, p);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k = 0;
    obs_t o;
    clear_mem();
    wait_n = 3;
    mem[0] = enc_r(5'd2, 5'd8, 5'd11, FN_ADD);
    mem[1] = enc_i(OP_ADDI, 5'd1, 5'd0, 16'd6);
    do_reset();
    while (!mem_req && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b0, 32'h0}) begin
      n_bad++; $display("FAIL midreset_drop: got req %b addr %h want 0 0", mem_req, mem_addr);
    end
    @(negedge clk);
    obs_q.delete();
    rd_q.delete();
    rst = 1'b1;
    ack_force = 1'b1;
    @(posedge clk); #1;
    ack_force = 1'b0;
    wait_obs(2, 200, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL midreset_timeout: got %0d retires want 2", obs_q.size()); end
    else begin
      n_cmp++;
      if (rd_q[0] !== 32'h0) begin n_bad++; $display("FAIL midreset_refetch: got %h want 0", rd_q[0]); end
      o = obs_q.pop_front();
      n_cmp++;
      if (o.res !== 32'h0) begin n_bad++; $display("FAIL regs_cleared: got %h want 0", o.res); end
      o = obs_q.pop_front();
      n_cmp++;
      if (o.res !== 32'd6) begin n_bad++; $display("FAIL midreset_result: got %h want 6", o.res); end
    end
    wait_n = 0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_alu();
    test_mem_wait();
    test_branch();
    test_trap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion want finish before 40000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
